// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding, memory map and counter sizing for run_ctrl
package run_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_LO,
        WR_HI,
        START,
        RUN,
        RD_LO,
        RD_HI,
        RD_CAP,
        RESP
    } state_t;

    localparam int unsigned OP_LO  = 0;
    localparam int unsigned OP_HI  = 1;
    localparam int unsigned RES_LO = 2;
    localparam int unsigned RES_HI = 3;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cyc_counter.sv
// rtl/cyc_counter.sv - loadable down-counter; expire flags the last enabled cycle of a count
module cyc_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - operand write, core start/run, result read-back controller
// Optional RUN_CTRL_TIMEOUT_EN: abort RUN after TIMEOUT_CYC cycles with an all-ones timeout result.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 400,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic              rsp_timeout,
    output logic              core_start,
    input  logic              core_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    localparam int CW = cnt_width(START_CYC, TIMEOUT_CYC);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] op;
    logic [15:0] rsp_q;
    logic        tmo_q;
    logic        start_exp;
    logic        run_tmo;

    cyc_counter #(.W(CW)) u_start_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (state == WR_HI),
        .load_val (CW'(START_CYC)),
        .en       (state == START),
        .expire   (start_exp)
    );

`ifdef RUN_CTRL_TIMEOUT_EN
    cyc_counter #(.W(CW)) u_tmo_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (state == START),
        .load_val (CW'(TIMEOUT_CYC)),
        .en       (state == RUN),
        .expire   (run_tmo)
    );
`else
    assign run_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op    <= '0;
            rsp_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                op    <= req_data;
                tmo_q <= 1'b0;
            end
            // core_done wins over a timeout expiring on the same edge
            if (state == RUN && !core_done && run_tmo) begin
                rsp_q <= 16'hFFFF;
                tmo_q <= 1'b1;
            end
            if (state == RD_HI) rsp_q[7:0]  <= mem_rdata;
            if (state == RD_CAP) rsp_q[15:8] <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        core_start = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WR_LO;
            end
            WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(OP_LO);
                mem_wdata = op[7:0];
                state_nxt = WR_HI;
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(OP_HI);
                mem_wdata = op[15:8];
                state_nxt = START;
            end
            START: begin
                core_start = 1'b1;
                if (start_exp) state_nxt = RUN;
            end
            RUN: begin
                if (core_done) state_nxt = RD_LO;
                else if (run_tmo) state_nxt = RESP;
            end
            RD_LO: begin
                mem_addr  = ADDR_W'(RES_LO);
                state_nxt = RD_HI;
            end
            RD_HI: begin
                mem_addr  = ADDR_W'(RES_HI);
                state_nxt = RD_CAP;
            end
            RD_CAP: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_data    = rsp_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - randomized scoreboard bench for run_ctrl with memory and core models
module tb_run_ctrl;

    localparam int START_CYC   = 2;
    localparam int TIMEOUT_CYC = 400;
    localparam int ADDR_W      = 8;
    localparam int RUN_OFF     = 3 + START_CYC;
    localparam int NT          = 14;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [15:0]       req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic              rsp_timeout;
    logic              core_start;
    logic              core_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata = 8'h00;

    run_ctrl #(.START_CYC(START_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .core_start  (core_start),
        .core_done   (core_done),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   stall_n = 0;
    logic [7:0] mem0 = 8'h00, mem1 = 8'h00, res_lo = 8'h00, res_hi = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read data memory; result bytes come from the core model
    always @(posedge clk) begin
        if (mem_we && mem_addr == ADDR_W'(0)) mem0 <= mem_wdata;
        if (mem_we && mem_addr == ADDR_W'(1)) mem1 <= mem_wdata;
        case (mem_addr)
            ADDR_W'(0): mem_rdata <= mem0;
            ADDR_W'(1): mem_rdata <= mem1;
            ADDR_W'(2): mem_rdata <= res_lo;
            ADDR_W'(3): mem_rdata <= res_hi;
            default:    mem_rdata <= 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'd1);
        check({tag, "_core_start"},  32'(core_start),  32'd0);
        check({tag, "_mem_we"},      32'(mem_we),      32'd0);
        check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
        check({tag, "_mem_wdata"},   32'(mem_wdata),   32'd0);
        check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
        check({tag, "_rsp_data"},    32'(rsp_data),    32'd0);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    endtask

    // consumer: holds rsp_ready low for stall_n cycles of each response
    initial begin
        int wcnt;
        wcnt = 0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rsp_valid) begin
                rsp_ready = 1'b0;
                wcnt = 0;
            end else if (wcnt >= stall_n) begin
                rsp_ready = 1'b1;
            end else begin
                wcnt++;
            end
        end
    end

    // monitor: protocol timing checks and scoreboard pop on each new response
    initial begin
        logic        busy, prev_valid, prev_cs, prev_tmo;
        logic [15:0] prev_data, acc_op;
        int          acc_cyc, cs_rise;
        exp_t        e;
        busy = 0; prev_valid = 0; prev_cs = 0; prev_tmo = 0;
        prev_data = 0; acc_op = 0; acc_cyc = -100; cs_rise = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0; prev_valid = 0; prev_cs = 0; acc_cyc = -100;
            end else begin
                if (mem_we || core_start) check("we_start_excl", 32'(mem_we && core_start), 32'd0);
                if (cyc == acc_cyc + 1)
                    check("wr_lo", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, ADDR_W'(0), acc_op[7:0]}));
                else if (cyc == acc_cyc + 2)
                    check("wr_hi", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, ADDR_W'(1), acc_op[15:8]}));
                else if (mem_we)
                    check("stray_we", 32'(mem_we), 32'd0);
                if (core_start && !prev_cs) begin
                    check("start_latency", 32'(cyc - acc_cyc), 32'd3);
                    cs_rise = cyc;
                end
                if (!core_start && prev_cs) check("start_len", 32'(cyc - cs_rise), 32'(START_CYC));
                prev_cs = core_start;
                if (rsp_valid) begin
                    check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    if (!prev_valid) begin
                        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("rsp_data", 32'(rsp_data), 32'(e.data));
                            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                            check("rsp_latency", 32'(cyc), 32'(e.cyc));
                        end
                    end else begin
                        check("hold_data", 32'(rsp_data), 32'(prev_data));
                        check("hold_tmo", 32'(rsp_timeout), 32'(prev_tmo));
                    end
                    prev_data = rsp_data;
                    prev_tmo  = rsp_timeout;
                    if (rsp_ready) busy = 0;
                end
                prev_valid = rsp_valid;
                if (req_valid && req_ready) begin
                    check("one_accept", 32'(busy), 32'd0);
                    busy = 1;
                    acc_cyc = cyc;
                    acc_op = req_data;
                end
            end
        end
    end

    // stimulus: req_valid held high; each accept plans the core behaviour and pushes the expectation
    initial begin
        logic got;
        int   a, done_off, spur, stall;
        logic do_reset;
        logic [7:0] lo, hi;
        reset = 1'b0; req_valid = 1'b0; req_data = 16'h0000; core_done = 1'b0;
        #2;
        check_reset("init");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        req_data  = 16'h0003;
        req_valid = 1'b1;
        for (int t = 0; t < NT; t++) begin
            got = 1'b0;
            for (int w = 0; w < 1000 && !got; w++) begin
                @(negedge clk);
                got = req_valid && req_ready && reset;
            end
            if (!got) begin
                check("accept_wait", 32'(got), 32'd1);
                break;
            end
            a = cyc;
            lo = 8'($urandom);
            hi = 8'($urandom);
            spur = 0;
            stall = 0;
            do_reset = 1'b0;
            case (t)
                0: begin lo = 8'h00; hi = 8'h42; done_off = 3 + 10; end
                1: begin stall = 5; done_off = $urandom_range(RUN_OFF, 20); end
                2: begin spur = $urandom_range(3, 4); done_off = $urandom_range(RUN_OFF + 1, 20); end
                3: begin do_reset = 1'b1; done_off = 0; end
                4: done_off = $urandom_range(RUN_OFF, 15);
                5: done_off = TMO_EN ? 0 : RUN_OFF + TIMEOUT_CYC + 50;
                6: done_off = RUN_OFF + TIMEOUT_CYC - 1;
                default: begin
                    done_off = $urandom_range(RUN_OFF, 40);
                    spur = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 4) : 0;
                    stall = $urandom_range(0, 3);
                end
            endcase
            res_lo = lo;
            res_hi = hi;
            stall_n = stall;
            if (!do_reset) begin
                if (done_off != 0 && (!TMO_EN || done_off < RUN_OFF + TIMEOUT_CYC))
                    exp_q.push_back('{{hi, lo}, 1'b0, a + done_off + 4});
                else
                    exp_q.push_back('{16'hFFFF, 1'b1, a + RUN_OFF + TIMEOUT_CYC});
            end
            @(posedge clk);
            #1;
            req_data = (t == 3) ? 16'h8F00 : 16'($urandom);
            if (do_reset) begin
                repeat (7) @(posedge clk);
                #2 reset = 1'b0;
                #1 check_reset("mid_run");
                @(posedge clk);
                #2 reset = 1'b1;
            end else if (done_off != 0) begin
                for (int k = 2; k <= done_off; k++) begin
                    @(posedge clk);
                    #1;
                    core_done = (k == spur) || (k == done_off);
                end
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
        for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL provide parameter START_CYC, default 2: number of cycles core_start is held high per run.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 400: maximum number of RUN cycles spent waiting for core_done.
REQ-003 SHALL provide parameter ADDR_W, default 8: data-memory address width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: operand request valid.
REQ-007 SHALL have port req_ready, output, 1: controller can accept a request.
REQ-008 SHALL have port req_data, input, 16: integer operand.
REQ-009 SHALL have port rsp_valid, output, 1: result valid.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port rsp_data, output, 16: result word, {mem[3], mem[2]}.
REQ-012 SHALL have port rsp_timeout, output, 1: the run ended by timeout.
REQ-013 SHALL have port core_start, output, 1: start to the core.
REQ-014 SHALL have port core_done, input, 1: done from the core.
REQ-015 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, 8), mem_we (output, 1) and mem_rdata (input, 8): data-memory port; read data is synchronous, valid one cycle after the address is presented.

Function
REQ-016 SHALL implement the states IDLE, WR_LO, WR_HI, START, RUN, RD_LO, RD_HI, RD_CAP and RESP.
REQ-017 SHALL assert req_ready only in IDLE; a handshake (req_valid && req_ready) SHALL register req_data and move to WR_LO.
REQ-018 SHALL in WR_LO drive mem_we=1, mem_addr=0, mem_wdata=op[7:0] for exactly one cycle, then move to WR_HI.
REQ-019 SHALL in WR_HI drive mem_we=1, mem_addr=1, mem_wdata=op[15:8] for exactly one cycle, then move to START.
REQ-020 SHALL hold core_start=1 for exactly START_CYC cycles in START, then move to RUN with core_start=0.
REQ-021 SHALL assert core_start for the first time exactly 3 cycles after the accepting edge.
REQ-022 SHALL ignore core_done in every state except RUN.
REQ-023 SHALL leave RUN for RD_LO on the first edge at which core_done=1 is sampled in RUN.
REQ-024 SHALL present mem_addr=2 in RD_LO and mem_addr=3 in RD_HI.
REQ-025 SHALL capture mem_rdata into rsp_data[7:0] in RD_HI and into rsp_data[15:8] in RD_CAP.
REQ-026 SHALL assert rsp_valid exactly 4 cycles after core_done is sampled.
REQ-027 SHALL in RESP hold rsp_valid, rsp_data and rsp_timeout stable until rsp_ready=1, then return to IDLE; the next request SHALL NOT be accepted in that same cycle.
REQ-028 SHALL keep mem_we=0 and mem_addr=0 in every state other than those stated above.
REQ-029 SHALL never assert mem_we and core_start in the same cycle.

Reset
REQ-030 SHALL, while reset=0, force state=IDLE and req_ready=1 immediately, independent of clk, regardless of state (including mid-RUN or mid-RESP).
REQ-031 SHALL, while reset=0, force core_start=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_timeout=0 and all counters to 0, immediately and independent of clk.
REQ-032 SHALL discard any in-flight request on reset, with no partial response.

Configuration
REQ-033 SHALL, with RUN_CTRL_TIMEOUT_EN defined, count cycles in RUN and, when TIMEOUT_CYC is reached without core_done, go directly to RESP with rsp_data=16'hFFFF and rsp_timeout=1, skipping all reads.
REQ-034 SHALL, without RUN_CTRL_TIMEOUT_EN defined, wait in RUN indefinitely and tie rsp_timeout to 0.
REQ-035 SHALL treat core_done and the timeout reached on the same edge as done (the reads proceed, rsp_timeout=0).

Structure
REQ-036 SHALL take the state enum and the address constants OP_LO=0, OP_HI=1, RES_LO=2 and RES_HI=3 from the shared package run_ctrl_pkg.
REQ-037 SHALL implement the START_CYC and TIMEOUT_CYC counting in one sub-module, cyc_counter, instantiated once per count (load, enable, expire).

Verification
REQ-038 SHALL be checked with: req_data=16'h0003; core_done 10 cycles after start; mem[2]=8'h00, mem[3]=8'h42 -> mem writes 03 then 00, core_start high 2 cycles, rsp_data=16'h4200, rsp_timeout=0.
REQ-039 SHALL be checked with: rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable throughout, req_ready=0 throughout.
REQ-040 SHALL be checked with: RUN_CTRL_TIMEOUT_EN defined, core_done never asserted -> rsp_valid after 400 RUN cycles with rsp_data=16'hFFFF and rsp_timeout=1.
REQ-041 SHALL be checked with: reset low for 1 cycle mid-RUN -> all outputs at reset values asynchronously; a next request of 16'h8F00 completes normally.
REQ-042 SHALL be checked with: req_valid held high continuously; core_done pulsed while in START -> pulse ignored; exactly one accept per run; the second accept occurs only after the rsp handshake.
REQ-043 SHALL be checked with: core_done and timeout on the same edge -> reads performed, rsp_timeout=0.
